sram_bus_arbiter: RTL and testbench

//  Shares one SRAM-like bus (req/addr_ok/data_ok) between the fetch port (M0)
//  and the MEM-stage data port (M1). Data has priority; grant is locked while
//  a forwarded req awaits addr_ok. Responses return in issue order and are

---
 rtl/sram_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
`timescale 1ns/1ps
// Shares one SRAM-like bus between the fetch port (M0) and the data port (M1).
// Data wins arbitration; an in-order owner FIFO routes each response back to its issuer.
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_addr,
    output logic                  m0_addr_ok,
    output logic                  m0_data_ok,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [1:0]            m1_size,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_addr_ok,
    output logic                  m1_data_ok,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    input  logic                  s_addr_ok,
    input  logic                  s_data_ok,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic                  err_orphan
);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [MAX_OUT-1:0] owner_q;
    logic               full, empty;
    logic               sel_m1, grant_req;
    logic               push, pop, head;

    assign full  = (count_q == CNT_W'(MAX_OUT));
    assign empty = (count_q == '0);

    // Grant selection, bus drive and next-state; a locked master keeps the bus until addr_ok.
    always_comb begin
        state_d   = ST_IDLE;
        sel_m1    = 1'b0;
        grant_req = 1'b0;
        s_wr      = 1'b0;
        s_size    = 2'd0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (!full) begin
                    if (m1_req) begin
                        sel_m1    = 1'b1;
                        grant_req = 1'b1;
                    end else begin
                        grant_req = m0_req;
                    end
                end
            end
            ST_LOCK0: grant_req = m0_req;
            ST_LOCK1: begin
                sel_m1    = 1'b1;
                grant_req = m1_req;
            end
            default: ;
        endcase
        s_req = grant_req & ~full & ~reset;
        if (s_req) begin
            if (sel_m1) begin
                s_wr    = m1_wr;
                s_size  = m1_size;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_size  = 2'd2;
                s_addr  = m0_addr;
            end
        end
        if (s_req && !s_addr_ok) begin
            state_d = sel_m1 ? ST_LOCK1 : ST_LOCK0;
        end
    end

    assign push       = s_req & s_addr_ok;
    assign pop        = s_data_ok & ~empty & ~reset;
    assign head       = owner_q[rptr_q];
    assign m0_addr_ok = push & ~sel_m1;
    assign m1_addr_ok = push & sel_m1;
    assign m0_data_ok = pop & ~head;
    assign m1_data_ok = pop & head;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner FIFO; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            owner_q    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wptr_q] <= sel_m1;
                wptr_q          <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
            if (s_data_ok && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
`timescale 1ns/1ps
// Randomised and directed bench for sram_bus_arbiter with a spec-level grant model
// and an in-order response scoreboard.
module tb_sram_bus_arbiter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned STRB_W  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_addr_ok, m0_data_ok;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req, m1_wr;
    logic [1:0]        m1_size;
    logic [STRB_W-1:0] m1_wstrb;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_addr_ok, m1_data_ok;
    logic [DATA_W-1:0] m1_rdata;
    logic              s_req, s_wr;
    logic [1:0]        s_size;
    logic [STRB_W-1:0] s_wstrb;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_addr_ok, s_data_ok;
    logic [DATA_W-1:0] s_rdata;
    logic              err_orphan;

    sram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: outstanding count, locked master (-1 none), sticky orphan flag.
    int   m_cnt  = 0;
    int   m_lock = -1;
    bit   m_err  = 1'b0;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hFFFF_0000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_addr = '0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_wstrb = 0; m1_addr = '0; m1_wdata = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
    endtask

    // Grant / request-path model checker; pushes expected responses on acceptance.
    initial begin
        int  own;
        bit  req, acc;
        logic [70:0] exp_pl;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                chk("reset_outputs", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, err_orphan}, 0);
                m_cnt = 0; m_lock = -1; m_err = 0;
                exp_q.delete();
            end else begin
                chk("err_orphan", err_orphan, m_err);
                if (m_lock == 0) begin
                    own = 0; req = m0_req;
                end else if (m_lock == 1) begin
                    own = 1; req = m1_req;
                end else if (m_cnt == MAX_OUT) begin
                    own = 0; req = 0;
                end else if (m1_req) begin
                    own = 1; req = 1;
                end else begin
                    own = 0; req = m0_req;
                end
                chk("s_req", s_req, req);
                if (req) begin
                    exp_pl = (own == 1) ? {m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata}
                                        : {1'b0, 2'd2, 4'h0, m0_addr, 32'h0};
                    chk("s_payload", {s_wr, s_size, s_wstrb, s_addr, s_wdata}, exp_pl);
                end
                acc = req && s_addr_ok;
                chk("m0_addr_ok", m0_addr_ok, acc && own == 0);
                chk("m1_addr_ok", m1_addr_ok, acc && own == 1);
                if (acc) exp_q.push_back('{own: bit'(own), data: rd_of(own == 1 ? m1_addr : m0_addr)});
                m_lock = (req && !s_addr_ok) ? own : -1;
                if (s_data_ok && m_cnt == 0) m_err = 1;
                m_cnt = m_cnt + (acc ? 1 : 0) - ((s_data_ok && m_cnt > 0) ? 1 : 0);
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (m0_data_ok || m1_data_ok || s_data_ok)) begin
                if (exp_q.size() == 0) begin
                    chk("resp_no_owner", {m0_data_ok, m1_data_ok}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_owner", {m0_data_ok, m1_data_ok}, e.own ? 2'b01 : 2'b10);
                    chk("resp_rdata", e.own ? m1_rdata : m0_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sp[$];
        bit          prev_dok;
        bit          a0, a1, sacc;
        logic [31:0] sa;
        reset = 1;
        idle_inputs();
        step(); step();
        reset = 0;

        // Random traffic with a responsive in-order slave.
        prev_dok = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            a0 = m0_addr_ok; a1 = m1_addr_ok; sacc = s_req && s_addr_ok; sa = s_addr;
            step();
            if (prev_dok) void'(sp.pop_front());
            if (sacc) sp.push_back(sa);
            if (sp.size() > 0 && $urandom_range(0, 2) == 0) begin
                s_data_ok = 1; s_rdata = rd_of(sp[0]); prev_dok = 1;
            end else begin
                s_data_ok = 0; s_rdata = $urandom; prev_dok = 0;
            end
            s_addr_ok = 1'($urandom_range(0, 1));
            if (m0_req && (a0 || $urandom_range(0, 15) == 0)) m0_req = 0;
            if (!m0_req && $urandom_range(0, 1) == 1) begin
                m0_req = 1; m0_addr = $urandom;
            end
            if (m1_req && (a1 || $urandom_range(0, 15) == 0)) m1_req = 0;
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                m1_req = 1; m1_wr = 1'($urandom_range(0, 1));
                m1_size = 2'($urandom_range(0, 2)); m1_wstrb = 4'($urandom);
                m1_addr = $urandom; m1_wdata = $urandom;
            end
        end

        idle_inputs();
        reset = 1; step(); reset = 0;

        // Both request: data port wins, fetch follows next cycle.
        m0_req = 1; m0_addr = 32'h1000_0000; m1_req = 1; m1_addr = 32'h2000_0000; s_addr_ok = 1;
        @(negedge clk);
        chk("t1_s_addr_m1", s_addr, 32'h2000_0000);
        chk("t1_m1_ok", {m1_addr_ok, m0_addr_ok}, 2'b10);
        step(); m1_req = 0;
        @(negedge clk);
        chk("t1_m0_next", {m0_addr_ok, s_addr}, {1'b1, 32'h1000_0000});
        step(); m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = rd_of(32'h2000_0000);
        step(); s_rdata = rd_of(32'h1000_0000);
        step(); idle_inputs(); step();

        // Fetch stalled by slave keeps the lock even when data port arrives.
        m0_req = 1; m0_addr = 32'h3000_0004;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin m1_req = 1; m1_addr = 32'h4000_0008; end
            @(negedge clk);
            chk("t2_lock0_addr", s_addr, 32'h3000_0004);
            step();
        end
        s_addr_ok = 1;
        @(negedge clk);
        chk("t2_m0_release", {m0_addr_ok, m1_addr_ok}, 2'b10);
        step(); m0_req = 0;
        @(negedge clk);
        chk("t2_m1_after", {m1_addr_ok, s_addr}, {1'b1, 32'h4000_0008});
        step(); m1_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = rd_of(32'h3000_0004);
        step(); s_rdata = rd_of(32'h4000_0008);
        step(); idle_inputs(); step();

        // Full blocks issue; responses route in order; push+pop keeps count.
        m0_req = 1; m0_addr = 32'hFFFF_AAAA; s_addr_ok = 1;
        step(); m0_req = 0; m1_req = 1; m1_addr = 32'hFFFF_5555;
        step(); m1_req = 0; m0_req = 1; m0_addr = 32'h1234_5678;
        @(negedge clk);
        chk("t3_full_block", {s_req, m0_addr_ok}, 2'b00);
        step(); s_data_ok = 1; s_rdata = 32'h0000_AAAA;
        @(negedge clk);
        chk("t3_still_full", s_req, 1'b0);
        chk("t3_m0_data", {m0_data_ok, m1_data_ok, m0_rdata}, {2'b10, 32'h0000_AAAA});
        step(); s_rdata = 32'h0000_5555;
        @(negedge clk);
        chk("t3_m1_data", {m0_data_ok, m1_data_ok, m1_rdata}, {2'b01, 32'h0000_5555});
        chk("t4_push_pop", {s_req, m0_addr_ok}, 2'b11);
        step(); m0_req = 0; s_addr_ok = 0; s_rdata = rd_of(32'h1234_5678);
        @(negedge clk);
        chk("t4_order", {m0_data_ok, m1_data_ok, m0_rdata}, {2'b10, rd_of(32'h1234_5678)});
        step(); idle_inputs(); step();

        // Response with nothing outstanding is an orphan; flag is sticky.
        s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t5_no_data_ok", {m0_data_ok, m1_data_ok}, 2'b00);
        step(); s_data_ok = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_sticky", err_orphan, 1'b1);
            step();
        end

        // Async reset while locked on M1 with one outstanding.
        reset = 1; step(); reset = 0;
        m0_req = 1; m0_addr = 32'h5000_0000; s_addr_ok = 1;
        step(); m0_req = 0; m1_req = 1; m1_addr = 32'h6000_0000; s_addr_ok = 0;
        step();
        @(negedge clk);
        chk("t6_locked_m1", {s_req, s_addr}, {1'b1, 32'h6000_0000});
        step(); m0_req = 1; s_addr_ok = 1; s_data_ok = 1; s_rdata = rd_of(32'h5000_0000);
        #2 reset = 1;
        #1;
        chk("t6_async_zero", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, err_orphan}, 0);
        step(); idle_inputs(); reset = 0; s_data_ok = 1; s_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("t6_late_no_route", {m0_data_ok, m1_data_ok}, 2'b00);
        step(); s_data_ok = 0;
        @(negedge clk);
        chk("t6_late_orphan", err_orphan, 1'b1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
